// File: rtl/npi_ict_arb_if.sv
// Request/grant bundle between the NPI port queues, the transfer FSM and the
// round-robin arbiter.
interface npi_ict_arb_if #(
  parameter int unsigned C_NUM_PORTS = 4
);
  logic                   PIM_InitDone;
  logic [C_NUM_PORTS-1:0] ReqPending;
  logic [C_NUM_PORTS-1:0] ReqRNW;
  logic                   rdsts_afull;
  logic                   upd_last_master;
  logic [C_NUM_PORTS-1:0] current_master;
  logic [C_NUM_PORTS-1:0] ReqGrant;
  logic [2:0]             ReqGrant_nr;
  logic [15:0]            arb_state;

  modport master (
    output PIM_InitDone, ReqPending, ReqRNW, rdsts_afull, upd_last_master, current_master,
    input  ReqGrant, ReqGrant_nr, arb_state
  );

  modport slave (
    input  PIM_InitDone, ReqPending, ReqRNW, rdsts_afull, upd_last_master, current_master,
    output ReqGrant, ReqGrant_nr, arb_state
  );
endinterface

// File: rtl/npi_ict_arb.sv
// Round-robin arbiter sharing the PIM address/write path between NPI ports.
// Optional macro NPI_ICT_ARB_PRIO0_EN makes port 0 a fixed high-priority port.
module npi_ict_arb #(
  parameter int unsigned C_NUM_PORTS = 4,
  parameter int unsigned C_LAST_INIT = 0
) (
  input  logic          Clk,
  input  logic          Rst,
  npi_ict_arb_if.slave  arb_if
);

  localparam int unsigned C_IDX_W = 3;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_GRANT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [C_NUM_PORTS-1:0] r_grant, w_grant_nxt;
  logic [C_IDX_W-1:0]     r_grant_nr, w_grant_nr_nxt;
  logic [C_IDX_W-1:0]     r_last, w_last_nxt;
  logic [C_NUM_PORTS-1:0] w_eligible;
  logic [C_IDX_W-1:0]     w_rr_idx, w_cm_idx, w_win_idx;
  logic                   w_rr_found, w_cm_found;
  logic [7:0]             w_dbg_elig;
`ifdef NPI_ICT_ARB_PRIO0_EN
  logic                   r_prio, w_prio_nxt, w_prio_win;
`endif

  function automatic logic f_bit(input logic [C_NUM_PORTS-1:0] v, input int unsigned i);
    return |(v & (C_NUM_PORTS'(1) << i));
  endfunction

  // Reads to a nearly full read-status queue are held back.
  assign w_eligible = arb_if.ReqPending & ~(arb_if.ReqRNW & {C_NUM_PORTS{arb_if.rdsts_afull}});

  // Round-robin scan starting one past the last served port.
  always_comb begin
    int unsigned v_idx;
    v_idx      = 0;
    w_rr_idx   = '0;
    w_rr_found = 1'b0;
    for (int unsigned i = 1; i <= C_NUM_PORTS; i++) begin
      v_idx = (32'(r_last) + i) % C_NUM_PORTS;
      if (!w_rr_found && f_bit(w_eligible, v_idx)) begin
        w_rr_found = 1'b1;
        w_rr_idx   = C_IDX_W'(v_idx);
      end
    end
  end

  // Lowest set bit of current_master; a zero vector leaves the pointer alone.
  always_comb begin
    w_cm_idx   = '0;
    w_cm_found = 1'b0;
    for (int unsigned i = 0; i < C_NUM_PORTS; i++) begin
      if (!w_cm_found && f_bit(arb_if.current_master, i)) begin
        w_cm_found = 1'b1;
        w_cm_idx   = C_IDX_W'(i);
      end
    end
  end

`ifdef NPI_ICT_ARB_PRIO0_EN
  assign w_prio_win = w_eligible[0];
  assign w_win_idx  = w_prio_win ? '0 : w_rr_idx;
`else
  assign w_win_idx  = w_rr_idx;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_INIT;
      r_grant    <= '0;
      r_grant_nr <= '0;
      r_last     <= C_IDX_W'(C_LAST_INIT);
`ifdef NPI_ICT_ARB_PRIO0_EN
      r_prio     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_nr <= w_grant_nr_nxt;
      r_last     <= w_last_nxt;
`ifdef NPI_ICT_ARB_PRIO0_EN
      r_prio     <= w_prio_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_nr_nxt = r_grant_nr;
    w_last_nxt     = r_last;
`ifdef NPI_ICT_ARB_PRIO0_EN
    w_prio_nxt     = r_prio;
`endif
    case (r_state)
      S_INIT: begin
        w_grant_nxt    = '0;
        w_grant_nr_nxt = '0;
        if (arb_if.PIM_InitDone) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (|w_eligible) begin
          w_grant_nxt    = C_NUM_PORTS'(1) << w_win_idx;
          w_grant_nr_nxt = w_win_idx;
          w_state_nxt    = S_GRANT;
`ifdef NPI_ICT_ARB_PRIO0_EN
          w_prio_nxt     = w_prio_win;
`endif
        end else begin
          w_grant_nxt    = '0;
          w_grant_nr_nxt = '0;
        end
      end
      S_GRANT: begin
        if (arb_if.upd_last_master) begin
          if (w_cm_found) w_last_nxt = w_cm_idx;
          w_grant_nxt = '0;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // Dead cycle lets the registered FIFO pop settle the empty flags.
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    w_dbg_elig = 8'(w_eligible);
`ifdef NPI_ICT_ARB_PRIO0_EN
    w_dbg_elig[7] = r_prio;
`endif
  end

  assign arb_if.ReqGrant    = r_grant;
  assign arb_if.ReqGrant_nr = r_grant_nr;
  assign arb_if.arb_state   = {w_dbg_elig, r_grant_nr, r_last, r_state};

endmodule

// File: tb/tb_npi_ict_arb.sv
// Randomized bench for npi_ict_arb against a transaction-level arbiter model.
module tb_npi_ict_arb;
  localparam int unsigned N     = 4;
  localparam int unsigned LAST0 = 0;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  npi_ict_arb_if #(.C_NUM_PORTS(N)) bus ();

  npi_ict_arb #(.C_NUM_PORTS(N), .C_LAST_INIT(LAST0)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .arb_if (bus.slave)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: initialised flag, granted port (-1 none), pending dead cycles, pointer.
  bit m_init  = 1'b0;
  int m_gnt   = -1;
  int m_nr    = 0;
  int m_last  = LAST0;
  int m_gap   = 0;
  bit m_prio  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] elig_of();
    logic [N-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++)
      e[i] = bus.ReqPending[i] && !(bus.ReqRNW[i] && bus.rdsts_afull);
    return e;
  endfunction

  task automatic model_edge();
    logic [N-1:0] e;
    int w;
    e = elig_of();
    if (Rst) begin
      m_init = 0; m_gnt = -1; m_nr = 0; m_last = LAST0; m_gap = 0; m_prio = 0;
    end else if (!m_init) begin
      if (bus.PIM_InitDone) m_init = 1;
    end else if (m_gnt >= 0) begin
      if (bus.upd_last_master) begin
        for (int i = N - 1; i >= 0; i--)
          if (bus.current_master[i]) m_last = i;
        m_gnt = -1;
        m_gap = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (e != 0) begin
      w = -1;
`ifdef NPI_ICT_ARB_PRIO0_EN
      m_prio = e[0];
      if (e[0]) w = 0;
`endif
      for (int k = 1; k <= N; k++)
        if (w < 0 && e[(m_last + k) % N]) w = (m_last + k) % N;
      m_gnt = w;
      m_nr  = w;
    end else begin
      m_nr = 0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_g;
    logic [7:0]   exp_e;
    int           exp_s;
    exp_g = (m_gnt >= 0) ? N'(1) << m_gnt : '0;
    exp_s = !m_init ? 0 : (m_gnt >= 0) ? 2 : (m_gap > 0) ? 3 : 1;
    exp_e = 8'(elig_of());
`ifdef NPI_ICT_ARB_PRIO0_EN
    exp_e[7] = m_prio;
`endif
    chk("grant", 32'(bus.ReqGrant), 32'(exp_g));
    if (!m_init || m_gnt >= 0) chk("grant_nr", 32'(bus.ReqGrant_nr), 32'(m_nr));
    chk("dbg_state", 32'(bus.arb_state[1:0]), 32'(exp_s));
    chk("dbg_last", 32'(bus.arb_state[4:2]), 32'(m_last));
    chk("dbg_elig", 32'(bus.arb_state[15:8]), 32'(exp_e));
  endtask

  task automatic step(input bit rst, input bit init, input logic [N-1:0] pend,
                      input logic [N-1:0] rnw, input bit afull, input bit upd,
                      input logic [N-1:0] cm);
    Rst                 = rst;
    bus.PIM_InitDone    = init;
    bus.ReqPending      = pend;
    bus.ReqRNW          = rnw;
    bus.rdsts_afull     = afull;
    bus.upd_last_master = upd;
    bus.current_master  = cm;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_outputs();
  endtask

  initial begin
    logic [N-1:0] seq [4];
    logic [N-1:0] g_prev;
    logic [N-1:0] pend, cm;
    bit           upd;
    seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0001; seq[3] = 4'b0010;

    step(1, 0, '0, '0, 0, 0, '0);
    step(1, 0, '0, '0, 0, 0, '0);
    for (int i = 0; i < 10; i++) step(0, 0, 4'b1111, '0, 0, 0, '0);
    chk("init_hold", 32'(bus.ReqGrant), 32'(0));
    step(0, 1, 4'b1111, '0, 0, 0, '0);
    step(0, 1, 4'b1111, '0, 0, 0, '0);
    chk("first_grant", 32'(bus.ReqGrant), 32'(4'b0010));
    chk("first_nr", 32'(bus.ReqGrant_nr), 32'(1));

    // Rotation with every port pending.
    g_prev = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 4'b1111, '0, 0, 1, g_prev);
      chk("gap_dead", 32'(bus.ReqGrant), 32'(0));
      step(0, 1, 4'b1111, '0, 0, 0, '0);
      step(0, 1, 4'b1111, '0, 0, 0, '0);
      chk("rotate", 32'(bus.ReqGrant), 32'(seq[k]));
      g_prev = seq[k];
    end

    // Read masked by afull; write port 2 wins.
    step(0, 1, 4'b0101, 4'b0001, 1, 1, 4'b0010);
    step(0, 1, 4'b0101, 4'b0001, 1, 0, '0);
    step(0, 1, 4'b0101, 4'b0001, 1, 0, '0);
    chk("afull_write", 32'(bus.ReqGrant), 32'(4'b0100));
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 4'b1101, 4'b0001, 0, 0, '0);
      chk("grant_hold", 32'(bus.ReqGrant), 32'(4'b0100));
    end
    step(0, 1, 4'b0001, 4'b0001, 1, 1, 4'b0100);
    for (int k = 0; k < 4; k++) step(0, 1, 4'b0001, 4'b0001, 1, 0, '0);
    chk("afull_block", 32'(bus.ReqGrant), 32'(0));
    step(0, 1, 4'b0001, 4'b0001, 0, 0, '0);
    chk("afull_release", 32'(bus.ReqGrant), 32'(4'b0001));

    // Reset in the middle of a grant.
    step(0, 1, 4'b1000, '0, 0, 1, 4'b0001);
    step(0, 1, 4'b1000, '0, 0, 0, '0);
    step(0, 1, 4'b1000, '0, 0, 0, '0);
    chk("grant_p3", 32'(bus.ReqGrant), 32'(4'b1000));
    step(1, 1, 4'b1000, '0, 0, 0, '0);
    chk("rst_grant", 32'(bus.ReqGrant), 32'(0));
    chk("rst_state", 32'(bus.arb_state[1:0]), 32'(0));
    step(0, 1, 4'b0011, '0, 0, 0, '0);
    step(0, 1, 4'b0011, '0, 0, 0, '0);
`ifdef NPI_ICT_ARB_PRIO0_EN
    chk("prio_grant", 32'(bus.ReqGrant), 32'(4'b0001));
    chk("prio_flag", 32'(bus.arb_state[15]), 32'(1));
`else
    chk("post_rst_grant", 32'(bus.ReqGrant), 32'(4'b0010));
`endif

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      pend = N'($urandom);
      if (m_gnt >= 0 && ($urandom % 3) == 0) begin
        upd = 1;
        cm  = (($urandom % 8) == 0) ? N'($urandom) : N'(1) << m_gnt;
      end else begin
        upd = (($urandom % 16) == 0);
        cm  = N'($urandom);
      end
      step(($urandom % 200) == 0, ($urandom % 20) != 0, pend, N'($urandom),
           ($urandom % 4) == 0, upd, cm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
